// File: rtl/rr_enable_arbiter.sv
// rr_enable_arbiter: four-way round-robin arbiter with lockable hold that loads the owner's data into a shared register
module rr_enable_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               C,
    input  logic               R,
    input  logic [3:0]         REQ,
    input  logic [3:0]         LOCK,
    input  logic [4*WIDTH-1:0] D,
    output logic [3:0]         GNT,
    output logic [WIDTH-1:0]   Q,
    output logic               E,
    output logic [1:0]         OWNER,
    output logic               BUSY
);
    typedef enum logic {IDLE, OWNED} state_t;
    localparam logic [3:0] HLIM = 4'(MAX_HOLD - 1);
    state_t           r_state, w_state_nx;
    logic [1:0]       r_ptr, r_owner, w_base, w_win;
    logic [3:0]       r_hcnt, r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             w_any, w_hold;
    assign w_any  = |REQ;
    assign w_hold = r_state == OWNED && REQ[r_owner] && LOCK[r_owner] && r_hcnt < HLIM;
    // a releasing owner searches from just past itself, otherwise from the stored pointer
    assign w_base = r_state == OWNED ? r_owner + 2'd1 : r_ptr;
    // first requester at or after w_base, wrapping 3->0
    always_comb begin
        w_win = w_base;
        for (int k = 3; k >= 0; k--)
            if (REQ[w_base + 2'(k)]) w_win = w_base + 2'(k);
    end
    // any pending request keeps or puts the arbiter in OWNED (a hold implies a request)
    always_comb begin
        w_state_nx = w_any ? OWNED : IDLE;
    end
    // state register
    always_ff @(posedge C or posedge R) begin
        if (R) r_state <= IDLE;
        else   r_state <= w_state_nx;
    end
    // hold extends the current grant; otherwise release and re-arbitrate on the same edge
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_hcnt  <= '0;
            r_gnt   <= '0;
            r_q     <= '0;
        end else if (w_hold) begin
            r_q    <= D[r_owner*WIDTH +: WIDTH];
            r_hcnt <= r_hcnt + 4'd1;
        end else begin
            if (r_state == OWNED) r_ptr <= r_owner + 2'd1;
            if (w_any) begin
                r_gnt   <= 4'b0001 << w_win;
                r_owner <= w_win;
                r_q     <= D[w_win*WIDTH +: WIDTH];
                r_hcnt  <= '0;
            end else begin
                r_gnt <= '0;
            end
        end
    end
    assign GNT   = r_gnt;
    assign Q     = r_q;
    assign E     = |r_gnt;
    assign OWNER = r_owner;
    assign BUSY  = r_state == OWNED;
endmodule

// File: tb/tb_rr_enable_arbiter.sv
// tb_rr_enable_arbiter: directed scenarios with hand-computed expectations for rr_enable_arbiter
module tb_rr_enable_arbiter;
    logic        C = 0, R = 1;
    logic [3:0]  REQ = 0, LOCK = 0;
    logic [31:0] D = 0;
    logic [3:0]  GNT;
    logic [7:0]  Q;
    logic        E, BUSY;
    logic [1:0]  OWNER;
    int n_checks = 0, n_fail = 0;

    rr_enable_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .C(C), .R(R), .REQ(REQ), .LOCK(LOCK), .D(D),
        .GNT(GNT), .Q(Q), .E(E), .OWNER(OWNER), .BUSY(BUSY)
    );

    always #5 C = ~C;

    task automatic step();
        @(posedge C);
        @(negedge C);
    endtask

    task automatic do_reset();
        R = 1;
        step();
        R = 0;
    endtask

    task automatic test_reset();
        R = 1; REQ = 4'b1111; LOCK = 4'b1111; D = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({GNT, Q, E, OWNER, BUSY} !== {4'b0, 8'h00, 1'b0, 2'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset cyc%0d: gnt=%b q=%h e=%b own=%0d busy=%b, want all zero", i, GNT, Q, E, OWNER, BUSY);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] eg;
        logic [7:0] eq;
        R = 1; REQ = 4'b1111; LOCK = 0; D = 32'hA3A2A1A0;
        step();
        R = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            eg = 4'b0001 << (i % 4);
            eq = 8'hA0 + 8'(i % 4);
            n_checks++;
            if ({GNT, Q, E, BUSY} !== {eg, eq, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL rotation cyc%0d: gnt=%b q=%h e=%b busy=%b, want gnt=%b q=%h e=1 busy=1", i, GNT, Q, E, BUSY, eg, eq);
            end
        end
        REQ = 0; D = 32'h11111111;
        step();
        n_checks++;
        if ({GNT, Q, E, BUSY, OWNER} !== {4'b0, 8'hA0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL rotation_idle: gnt=%b q=%h e=%b busy=%b own=%0d, want 0000 a0 0 0 0", GNT, Q, E, BUSY, OWNER);
        end
    endtask

    task automatic test_lock_hold();
        logic [3:0] eg [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0100};
        logic [7:0] eq [6] = '{8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h22};
        REQ = 4'b1100; LOCK = 4'b0100; D = 32'h33221100;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if ({GNT, Q, E} !== {eg[i], eq[i], 1'b1}) begin
                n_fail++;
                $display("FAIL lock_hold cyc%0d: gnt=%b q=%h e=%b, want gnt=%b q=%h e=1", i, GNT, Q, E, eg[i], eq[i]);
            end
        end
    endtask

    task automatic test_sole_lock();
        int bad = 0;
        REQ = 4'b0001; LOCK = 4'b0001; D = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            D[7:0] = 8'(8'h40 + i);
            step();
            if ({GNT, E, OWNER, Q} !== {4'b0001, 1'b1, 2'd0, 8'(8'h40 + i)}) begin
                bad++;
                $display("FAIL sole_lock cyc%0d: gnt=%b e=%b own=%0d q=%h, want 0001 1 0 %h", i, GNT, E, OWNER, Q, 8'(8'h40 + i));
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_drop();
        REQ = 4'b0100; LOCK = 4'b0100; D = 32'h00500000;
        do_reset();
        step();
        D = 32'h00510000;
        step();
        n_checks++;
        if ({GNT, Q, OWNER} !== {4'b0100, 8'h51, 2'd2}) begin
            n_fail++;
            $display("FAIL drop_hold: gnt=%b q=%h own=%0d, want 0100 51 2", GNT, Q, OWNER);
        end
        REQ = 0; D = 32'h00770000;
        step();
        n_checks++;
        if ({GNT, E, BUSY, Q, OWNER} !== {4'b0, 1'b0, 1'b0, 8'h51, 2'd2}) begin
            n_fail++;
            $display("FAIL drop_release: gnt=%b e=%b busy=%b q=%h own=%0d, want 0000 0 0 51 2", GNT, E, BUSY, Q, OWNER);
        end
    endtask

    task automatic test_async_reset();
        REQ = 4'b0010; LOCK = 4'b0010; D = 32'h00001100;
        do_reset();
        step();
        step();
        n_checks++;
        if ({GNT, Q, BUSY} !== {4'b0010, 8'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL async_pre: gnt=%b q=%h busy=%b, want 0010 11 1", GNT, Q, BUSY);
        end
        #1 R = 1;
        #1;
        n_checks++;
        if ({GNT, Q, E, BUSY, OWNER} !== {4'b0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL async_clear: gnt=%b q=%h e=%b busy=%b own=%0d, want all zero", GNT, Q, E, BUSY, OWNER);
        end
        R = 0; REQ = 4'b1000; LOCK = 0; D = 32'h99000000;
        step();
        n_checks++;
        if ({GNT, Q, E, OWNER} !== {4'b1000, 8'h99, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL async_regrant: gnt=%b q=%h e=%b own=%0d, want 1000 99 1 3", GNT, Q, E, OWNER);
        end
    endtask

    initial begin
        @(negedge C);
        test_reset();
        test_rotation();
        test_lock_hold();
        test_sole_lock();
        test_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_enable_arbiter.md
RR_ENABLE_ARBITER -- requirements
Module: rr_enable_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of each requester data word and of Q.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles per owner; legal range 1..16.
REQ-003 C  input  1  clock; all sequential state updates on rising edge.
REQ-004 R  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 REQ  input  4  per-requester request, bit i = requester i.
REQ-006 LOCK  input  4  per-requester hold request; meaningful only with matching REQ bit.
REQ-007 D  input  4*WIDTH  packed requester data, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 GNT  output  4  registered one-hot grant, all-zero when no owner.
REQ-009 Q  output  WIDTH  shared register contents, loaded from owner's D.
REQ-010 E  output  1  write strobe, high in every cycle Q was loaded at the preceding edge (E = |GNT).
REQ-011 OWNER  output  2  index of current owner; holds last owner when idle.
REQ-012 BUSY  output  1  high while in state OWNED.

Function
REQ-013 Internal state SHALL be: FSM {IDLE, OWNED}, 2-bit priority pointer PTR, 4-bit hold counter HCNT.
REQ-014 Arbitration SHALL search REQ starting at index PTR, ascending, wrapping 3->0; first asserted bit wins.
REQ-015 IDLE, REQ==0: stay IDLE; GNT=0, E=0, Q and OWNER hold.
REQ-016 IDLE, REQ!=0: at the edge, go OWNED; GNT=onehot(winner), OWNER=winner, Q<=D[winner], HCNT<=0; latency REQ->GNT/Q = 1 edge.
REQ-017 OWNED, owner w, REQ[w]&LOCK[w]&(HCNT<MAX_HOLD-1): stay; GNT unchanged, Q<=D[w], HCNT<=HCNT+1.
REQ-018 OWNED, otherwise (REQ[w]=0, LOCK[w]=0, or HCNT==MAX_HOLD-1): release; PTR<=w+1 mod 4; same edge re-arbitrate with PTR=w+1.
REQ-019 On release with REQ!=0: new winner granted in the very next cycle (no idle bubble), HCNT<=0, Q<=D[winner].
REQ-020 On release with REQ==0: go IDLE; GNT<=0, E=0, Q holds last value.
REQ-021 Sole requester w at release (forced expiry): w SHALL be regranted back-to-back with HCNT reset to 0; GNT stays one-hot w continuously.
REQ-022 Owner dropping REQ[w] SHALL release at the next edge regardless of LOCK[w]; Q is not loaded at that edge from D[w].
REQ-023 LOCK[i] with REQ[i]=0 SHALL be ignored; LOCK of non-owners SHALL be ignored.
REQ-024 MAX_HOLD=1: every grant lasts exactly one cycle; LOCK has no effect.
REQ-025 GNT SHALL never have more than one bit set; E and BUSY SHALL be equal in every cycle.
REQ-026 D[i] SHALL be sampled only at edges where requester i is (or becomes) owner.

Reset
REQ-027 R=1 SHALL immediately, without clock edge, force: GNT=0, Q=0, E=0, OWNER=0, BUSY=0, FSM=IDLE, PTR=0, HCNT=0.
REQ-028 While R=1, REQ/LOCK/D SHALL be ignored; first arbitration occurs at first rising edge with R=0.
REQ-029 Reset asserted mid-grant or mid-hold SHALL abort the grant; no partial Q load.

Verification
REQ-030 R=1 with REQ=4'b1111, D nonzero -> GNT=0, Q=0, E=0, OWNER=0, BUSY=0 on every cycle.
REQ-031 Release R, REQ=4'b1111, LOCK=0, D[i]=8'hA0+i -> GNT 0001,0010,0100,1000,0001 on consecutive cycles; Q A0,A1,A2,A3,A0; E=1 throughout.
REQ-032 MAX_HOLD=4, REQ=4'b1100, LOCK=4'b0100 from reset release -> GNT=0100 for exactly 4 cycles, then 1000 for 1 cycle, then 0100 again.
REQ-033 REQ=0001, LOCK=0001 held 20 cycles -> GNT=0001 and E=1 continuously, OWNER=0, Q tracks D[0] each cycle.
REQ-034 Owner 2 locked, REQ[2] dropped at cycle 2 of hold, others idle -> next cycle GNT=0, E=0, BUSY=0, Q holds last D[2] value.
REQ-035 R pulsed high between edges during hold -> GNT, Q, E, BUSY go 0 before next edge; after release, REQ=1000 -> GNT=1000 one edge later.
